pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, handshaked pipeline register. Successor to the fixed stall-hold ID/EX register.
- Carries an arbitrary-width payload (packed data plus control fields) between pipeline stages using valid/ready flow control.
- Provides an optional 2-entry skid buffer, a synchronous flush that kills in-flight entries, and a saturating backpressure counter for performance monitoring.
- Instantiated at every stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- WIDTH, 32+32+32+32+32+15+16, payload bits per entry.
- SKID_EN, 1. 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- CNT_W, 16, width of the backpressure counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream offers a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents a payload.
- out_ready  in  1  downstream accepts a payload.
- out_data  out  WIDTH  head payload.
- occupancy  out  2  entries held: 0, 1 or 2.
- bp_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
- bp_clr  in  1  synchronous clear of bp_cycles.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=0, asynchronous): state=EMPTY, main and skid registers=0, bp_cycles=0. Outputs at reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (SKID_EN=1) or 1 by the combinational equation (SKID_EN=0). Release is synchronous to clk; the first accept can occur on the first edge after release.
- States (SKID_EN=1): EMPTY, ONE, FULL.
- Outputs per state:
  - out_valid = (state != EMPTY).
  - out_data = main register.
  - in_ready = (state != FULL), a function of registered state only.
  - occupancy = 0, 1, 2 for EMPTY, ONE, FULL.
- EMPTY: in_fire -> ONE, main<=in_data.
- ONE:
  - in_fire & out_fire -> ONE, main<=in_data.
  - in_fire & !out_ready -> FULL, skid<=in_data; main is held.
  - !in_fire & out_fire -> EMPTY.
  - otherwise hold.
- FULL (in_ready=0):
  - out_fire -> ONE, main<=skid.
  - otherwise hold.
- SKID_EN=0: only EMPTY and ONE exist; FULL is unreachable and the skid register is not built. in_ready = !out_valid | out_ready (combinational). Transitions as above without the FULL arc.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1 payload per cycle while out_ready=1.
- Ordering is strict FIFO: no payload is dropped or duplicated except on flush.
- flush=1 has priority over everything:
  - next state is EMPTY;
  - any in_fire in the same cycle is discarded;
  - data registers keep their contents, and out_data is don't-care while out_valid=0;
  - in_ready keeps its normal state-derived value during the flush cycle.
- bp_cycles:
  - increments by 1 each cycle out_valid & !out_ready;
  - saturates at 2^CNT_W-1;
  - bp_clr=1 loads 0, taking priority over increment;
  - unaffected by flush.
- No combinational path from in_valid or in_data to any output. With SKID_EN=0, out_ready->in_ready is the only combinational path.
- Mid-operation reset: all entries are lost immediately and the outputs take their reset values asynchronously.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {ST_EMPTY=0, ST_ONE=1, ST_FULL=2};
  - typedef struct packed id_ex_payload_t, giving the field layout for the ID/EX instance;
  - localparam ID_EX_W = $bits(id_ex_payload_t).
- Sub-module sat_counter (parameter W; ports clk, rst, inc, clr, count), reused for the other performance counters.

Test Plan:
- Reset, then a stream 0x11, 0x22, 0x33 with out_ready=1 held -> out_data 0x11, 0x22, 0x33 on consecutive cycles, 1 cycle after each in_fire; occupancy stays 1; bp_cycles=0.
- SKID_EN=1: accept 0xA0, drop out_ready, offer 0xB0 -> occupancy=2, in_ready=0, out_data=0xA0. Raise out_ready -> 0xA0 then 0xB0; occupancy 2->1->0.
- FULL with 0xC1/0xC2, then flush=1 and in_valid=1 with 0xC3 in the same cycle -> next cycle out_valid=0, occupancy=0; 0xC3 never appears at the output.
- out_valid=1 with out_ready=0 for 5 cycles, then bp_clr -> bp_cycles reads 5, then 0. With CNT_W=4 and 20 stalled cycles -> bp_cycles sticks at 15.
- SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 in the same cycle, and a new payload replaces the old with no bubble.
- Assert rst=0 mid-cycle while FULL -> out_valid, occupancy, out_data and bp_cycles go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for elastic pipeline stages
package pipe_pkg;

  // Stage fill state; the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // Field layout carried across the ID/EX boundary.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [14:0] ctrl;
    logic [15:0] tag;
  } id_ex_payload_t;

  localparam int ID_EX_W = $bits(id_ex_payload_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q, count_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - valid/ready pipeline register with optional skid entry
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH   = ID_EX_W,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bp_cycles,
  input  logic             bp_clr
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign in_fire = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and register load strobes; flush overrides every transition and load.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_fire && SKID_EN) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Outputs derived from registered state; only out_ready may reach in_ready without a register.
  always_comb begin
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
    if (SKID_EN) begin
      in_ready = (state_q != ST_FULL);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  // Head register: loads from upstream or promotes the skid entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_data;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [WIDTH-1:0] skid_q;

      // Second entry, captured when the head is stalled.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_q <= '0;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end

      assign skid_data = skid_q;
    end else begin : g_no_skid
      logic unused_load_skid;
      assign unused_load_skid = load_skid;
      assign skid_data        = '0;
    end
  endgenerate

  assign out_data = main_q;

  sat_counter #(
    .W (CNT_W)
  ) u_bp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .clr   (bp_clr),
    .count (bp_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  localparam int W = 8;

  logic clk;
  logic rst;

  // Skid-enabled stage; a CNT_W=4 copy shares its inputs.
  logic         flush, in_valid, out_ready, bp_clr;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  bp_cycles;

  logic         c4_in_ready, c4_out_valid;
  logic [W-1:0] c4_out_data;
  logic [1:0]   c4_occupancy;
  logic [3:0]   c4_bp_cycles;

  // Single-register stage.
  logic         n_flush, n_in_valid, n_out_ready, n_bp_clr;
  logic [W-1:0] n_in_data;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occupancy;
  logic [15:0]  n_bp_cycles;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] expn_q[$];

  pipe_stage_elastic #(.WIDTH(W), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bp_cycles(bp_cycles), .bp_clr(bp_clr)
  );

  pipe_stage_elastic #(.WIDTH(W), .SKID_EN(1'b1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_data(in_data), .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
    .occupancy(c4_occupancy), .bp_cycles(c4_bp_cycles), .bp_clr(bp_clr)
  );

  pipe_stage_elastic #(.WIDTH(W), .SKID_EN(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .bp_cycles(n_bp_cycles), .bp_clr(n_bp_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output is compared against the head of its expected queue.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("skid_unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("skid_out_data", {24'd0, out_data}, {24'd0, e});
        end
      end
      if (rst && n_out_valid && n_out_ready) begin
        if (expn_q.size() == 0) begin
          check("noskid_unexpected_out", {24'd0, n_out_data}, 32'hFFFF_FFFF);
        end else begin
          e = expn_q.pop_front();
          check("noskid_out_data", {24'd0, n_out_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bp_clr = 1'b0; in_data = '0;
    n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0; n_bp_clr = 1'b0; n_in_data = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_bp_cycles", {16'd0, bp_cycles}, 32'd0);
    check("rst_noskid_in_ready", {31'd0, n_in_ready}, 32'd1);
    next_cycle();
    rst = 1'b1;

    // Streaming with out_ready held high.
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1; exp_q.push_back(8'h11);
    next_cycle();
    in_data = 8'h22; exp_q.push_back(8'h22);
    #1 check("stream_occ_a", {30'd0, occupancy}, 32'd1);
    check("stream_head_a", {24'd0, out_data}, 32'h11);
    next_cycle();
    in_data = 8'h33; exp_q.push_back(8'h33);
    #1 check("stream_occ_b", {30'd0, occupancy}, 32'd1);
    check("stream_head_b", {24'd0, out_data}, 32'h22);
    next_cycle();
    in_valid = 1'b0;
    #1 check("stream_head_c", {24'd0, out_data}, 32'h33);
    next_cycle();
    #1 check("stream_drained_occ", {30'd0, occupancy}, 32'd0);
    check("stream_bp", {16'd0, bp_cycles}, 32'd0);

    // Skid entry fill and drain.
    in_valid = 1'b1; in_data = 8'hA0; out_ready = 1'b0; exp_q.push_back(8'hA0);
    next_cycle();
    in_data = 8'hB0; exp_q.push_back(8'hB0);
    next_cycle();
    in_valid = 1'b0;
    #1 check("skid_occ_full", {30'd0, occupancy}, 32'd2);
    check("skid_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("skid_head_full", {24'd0, out_data}, 32'hA0);
    out_ready = 1'b1;
    next_cycle();
    #1 check("skid_occ_one", {30'd0, occupancy}, 32'd1);
    check("skid_head_promoted", {24'd0, out_data}, 32'hB0);
    next_cycle();
    #1 check("skid_occ_empty", {30'd0, occupancy}, 32'd0);

    // Flush while full, with a same-cycle offer that must be dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
    next_cycle();
    in_data = 8'hC2;
    next_cycle();
    flush = 1'b1; in_data = 8'hC3;
    #1 check("flush_in_ready_during", {31'd0, in_ready}, 32'd0);
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1 check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    out_ready = 1'b1;
    next_cycle();
    next_cycle();
    #1 check("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure counter: count, clear priority, saturation.
    bp_clr = 1'b1;
    next_cycle();
    bp_clr = 1'b0;
    #1 check("bp_cleared", {16'd0, bp_cycles}, 32'd0);
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0; exp_q.push_back(8'h5A);
    next_cycle();
    in_valid = 1'b0;
    repeat (5) next_cycle();
    check("bp_five", {16'd0, bp_cycles}, 32'd5);
    check("bp_five_cnt4", {28'd0, c4_bp_cycles}, 32'd5);
    bp_clr = 1'b1;
    next_cycle();
    bp_clr = 1'b0;
    check("bp_clr_over_inc", {16'd0, bp_cycles}, 32'd0);
    repeat (20) next_cycle();
    check("bp_twenty", {16'd0, bp_cycles}, 32'd20);
    check("bp_saturated_cnt4", {28'd0, c4_bp_cycles}, 32'd15);
    out_ready = 1'b1;
    next_cycle();
    next_cycle();

    // Single-register stage: combinational in_ready, no-bubble replacement.
    n_in_valid = 1'b1; n_in_data = 8'h71; n_out_ready = 1'b0; expn_q.push_back(8'h71);
    #1 check("noskid_ready_empty", {31'd0, n_in_ready}, 32'd1);
    next_cycle();
    n_in_data = 8'h72;
    #1 check("noskid_ready_stalled", {31'd0, n_in_ready}, 32'd0);
    n_out_ready = 1'b1; expn_q.push_back(8'h72);
    #1 check("noskid_ready_comb", {31'd0, n_in_ready}, 32'd1);
    next_cycle();
    n_in_valid = 1'b0;
    #1 check("noskid_no_bubble_valid", {31'd0, n_out_valid}, 32'd1);
    check("noskid_no_bubble_data", {24'd0, n_out_data}, 32'h72);
    next_cycle();
    #1 check("noskid_drained", {30'd0, n_occupancy}, 32'd0);

    // Asynchronous reset while full.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
    next_cycle();
    in_data = 8'hD2;
    next_cycle();
    in_valid = 1'b0;
    #1 check("arst_pre_full", {30'd0, occupancy}, 32'd2);
    #1 rst = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_occ", {30'd0, occupancy}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_bp", {16'd0, bp_cycles}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b1; exp_q.push_back(8'hE1);
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    next_cycle();

    check("skid_queue_left", exp_q.size(), 32'd0);
    check("noskid_queue_left", expn_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
